i2s_tx_master: RTL and testbench

I2S_TX_MASTER -- requirements
Module: i2s_tx_master

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_bclk_gen.sv | 40 ++++
 rtl/i2s_tx_master.sv | 136 +++++++++++++
 tb/tb_i2s_tx_master.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the Tx master and the matching Rx side.
// Contents: default sample/slot widths and the run-control state enum.
package i2s_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_SLOT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_HALF while run is high.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   run         divider enable; low forces divider = 0 and bclk = 0
//   bclk        bit clock output (registered)
//   bclk_fall   combinational strobe, high in the clk cycle whose edge drives bclk 1->0
module i2s_bclk_gen #(
    parameter int BCLK_HALF = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic bclk_fall
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

    logic [7:0] div;
    logic       tc;

    assign tc        = run && (div == DIV_LAST);
    assign bclk_fall = tc && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (!run) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (tc) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S transmit master: one-entry sample-pair buffer feeding a frame shift
// register, with bclk/lrck generation and underrun reporting.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   en                  run enable (stops only at a frame boundary)
//   in_valid/in_ready   sample-pair handshake; in_ready = buffer empty
//   l_data, r_data      left/right samples, two's complement
//   bclk, lrck, sdata   I2S bus (lrck 0 = left)
//   underrun            one-clk pulse when a frame loads from an empty buffer
//   underrun_cnt        saturating underrun count
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to build the underrun
// counter; otherwise underrun_cnt is tied to 0.
module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 16,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SLOT_W    = DEF_SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BC_W    = $clog2(FRAME_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] BC_SLOT = BC_W'(SLOT_W);

    i2s_state_e         state, next_state;
    logic               run, bclk_fall, wrap, go_idle, frame_load, accept;
    logic [BC_W-1:0]    bitcnt, bitcnt_nxt;
    logic               full;
    logic [DATA_W-1:0]  l_buf, r_buf;
    logic [FRAME_W-1:0] shreg, frame_vec;

    assign run = (state != IDLE);

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .bclk      (bclk),
        .bclk_fall (bclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = RUN;
            RUN:     if (!en) next_state = STOP;
            STOP:    if (en) next_state = RUN;
                     else if (wrap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A boundary reached while stopping returns to IDLE instead of loading.
    assign wrap       = bclk_fall && (bitcnt == BC_LAST);
    assign go_idle    = (state == STOP) && !en && wrap;
    assign frame_load = wrap && !go_idle;
    assign accept     = in_valid && !full;
    assign in_ready   = ~full;
    assign bitcnt_nxt = (bitcnt == BC_LAST) ? '0 : bitcnt + 1'b1;

    // Slot layout: MSB-aligned sample, zero padded to SLOT_W.
    always_comb begin
        frame_vec = '0;
        if (full) begin
            frame_vec[FRAME_W-1 -: DATA_W] = l_buf;
            frame_vec[SLOT_W-1 -: DATA_W]  = r_buf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt   <= BC_LAST;
            lrck     <= 1'b1;
            sdata    <= 1'b0;
            shreg    <= '0;
            full     <= 1'b0;
            l_buf    <= '0;
            r_buf    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load && !full;
            // An accept coinciding with an empty-buffer load stays buffered.
            if (accept) begin
                l_buf <= l_data;
                r_buf <= r_data;
                full  <= 1'b1;
            end else if (frame_load) begin
                full  <= 1'b0;
            end
            if (go_idle) begin
                bitcnt <= BC_LAST;
                lrck   <= 1'b1;
                sdata  <= 1'b0;
                shreg  <= '0;
            end else if (bclk_fall) begin
                bitcnt <= bitcnt_nxt;
                lrck   <= (bitcnt_nxt >= BC_SLOT);
                // The MSB shifted out at the load is the previous frame's last
                // bit, which gives the one-bclk I2S delay and the carry bit.
                sdata  <= shreg[FRAME_W-1];
                shreg  <= frame_load ? frame_vec : (shreg << 1);
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= '0;
        else if (frame_load && !full && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_master.sv
module tb_i2s_tx_master;

    localparam int H = 2;
    localparam int D = 16;
    localparam int S = 16;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [D-1:0] l_data = '0, r_data = '0;
    logic bclk, lrck, sdata, underrun;
    logic [15:0] underrun_cnt;

    i2s_tx_master #(.BCLK_HALF(H), .DATA_W(D), .SLOT_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .l_data(l_data), .r_data(r_data), .bclk(bclk), .lrck(lrck), .sdata(sdata),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stream bit j of a frame: MSB-first left slot then right slot, zero padded.
    function automatic bit sbit(input logic [D-1:0] l, input logic [D-1:0] r, input int j);
        if (j < S) return (j < D) ? l[D-1-j] : 1'b0;
        return ((j - S) < D) ? r[D-1-(j-S)] : 1'b0;
    endfunction

    // ---------------- behavioural model ----------------
    // Time is counted in clks since the run started; bclk phase, bit index and
    // frame boundaries all follow arithmetically from that count.
    bit m_run, m_stop, m_full, m_bclk, m_lrck, m_sdata, m_under;
    logic [D-1:0] m_l, m_r, c_l, c_r;
    logic [15:0] m_cnt;
    int n;

    initial begin
        bit en_s, acc;
        int f, b;
        m_run = 0; m_stop = 0; m_full = 0; m_bclk = 0; m_lrck = 1; m_sdata = 0;
        m_under = 0; m_l = '0; m_r = '0; c_l = '0; c_r = '0; m_cnt = '0; n = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_stop = 0; m_full = 0; m_bclk = 0; m_lrck = 1; m_sdata = 0;
                m_under = 0; c_l = '0; c_r = '0; m_cnt = '0; n = 0;
            end else begin
                en_s = en;
                acc = in_valid && !m_full;
                m_under = 0;
                if (!m_run) begin
                    if (en_s) begin m_run = 1; m_stop = 0; n = 0; end
                end else begin
                    n++;
                    m_bclk = ((n / H) % 2) == 1;
                    if (n % (2*H) == 0) begin
                        f = n / (2*H);
                        b = (f - 1) % (2*S);
                        if (b == 0 && m_stop && !en_s) begin
                            m_run = 0; m_lrck = 1; m_sdata = 0; c_l = '0; c_r = '0;
                        end else begin
                            if (b == 0) begin
                                m_sdata = sbit(c_l, c_r, 2*S-1);
                                if (m_full) begin
                                    c_l = m_l; c_r = m_r; m_full = 0;
                                end else begin
                                    c_l = '0; c_r = '0; m_under = 1;
                                    if (CNT_ON != 0 && m_cnt != 16'hFFFF) m_cnt++;
                                end
                            end else begin
                                m_sdata = sbit(c_l, c_r, b - 1);
                            end
                            m_lrck = (b >= S);
                        end
                    end
                    m_stop = m_run && !en_s;
                end
                if (acc) begin m_full = 1; m_l = l_data; m_r = r_data; end
            end
        end
    end

    // ---------------- compare + I2S decoder ----------------
    logic [16:0] dec_q[$];
    logic [S-1:0] dec_sh = '0;
    int dec_cnt = 0;
    logic dec_ws = 1'b1, prev_bclk = 1'b0, prev_lrck = 1'b1;
    int r_lo = 0, r_hi = 0, r_all = 0, lo_edges = 0, und_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("bclk", {31'd0, bclk}, {31'd0, m_bclk});
            check("lrck", {31'd0, lrck}, {31'd0, m_lrck});
            check("sdata", {31'd0, sdata}, {31'd0, m_sdata});
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
            check("underrun", {31'd0, underrun}, {31'd0, m_under});
            check("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, m_cnt});
            if (underrun === 1'b1) und_seen++;
            if (!rst_n) begin
                dec_cnt = 0; dec_ws = 1'b1; prev_bclk = 1'b0; prev_lrck = 1'b1;
            end else begin
                if (prev_lrck && !lrck) lo_edges++;
                if (bclk && !prev_bclk) begin
                    r_all++;
                    if (lrck) r_hi++; else r_lo++;
                    dec_sh = {dec_sh[S-2:0], sdata};
                    if (lrck != dec_ws) begin
                        if (dec_cnt >= S) dec_q.push_back({dec_ws, dec_sh[S-1 -: D]});
                        dec_cnt = 1;
                        dec_ws = lrck;
                    end else begin
                        dec_cnt++;
                    end
                end
                prev_bclk = bclk;
                prev_lrck = lrck;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        en = 1'b1;
        wait_n(1);
    endtask

    task automatic offer(input logic [D-1:0] l, input logic [D-1:0] r);
        in_valid = 1'b1; l_data = l; r_data = r;
        wait_n(1);
        in_valid = 1'b0;
    endtask

    logic [2*D-1:0] acc_q[$];

    initial begin
        int base, b_und, b_lo, b_hi, b_all, b_edges, nd, p;
        bit hs;
        logic [16:0] expw;
        logic [2*D-1:0] pr;

        // reset state
        reset_dut();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_bclk", {31'd0, bclk}, 32'd0);
        check("rst_lrck", {31'd0, lrck}, 32'd1);
        check("rst_cnt", {16'd0, underrun_cnt}, 32'd0);

        // first frame with empty buffer: zeros, one underrun, 16 low / 16 high
        base = dec_q.size(); b_und = und_seen;
        start_run();
        wait_n(4);
        b_lo = r_lo; b_hi = r_hi;
        wait_n(127);
        check("empty_underrun_once", und_seen - b_und, 32'd1);
        check("empty_lrck_low_bclks", r_lo - b_lo, 32'd16);
        check("empty_lrck_high_bclks", r_hi - b_hi, 32'd16);
        check("empty_dec_avail", {31'd0, dec_q.size() > base}, 32'd1);
        if (dec_q.size() > base) check("empty_left_word", {15'd0, dec_q[base]}, 32'h0);

        // A5C3 / 8001 preloaded
        reset_dut();
        base = dec_q.size();
        offer(16'hA5C3, 16'h8001);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        start_run();
        wait_n(3);
        check("ready_before_load", {31'd0, in_ready}, 32'd0);
        wait_n(1);
        check("ready_after_load", {31'd0, in_ready}, 32'd1);
        wait_n(140);
        check("lit_dec_avail", {31'd0, dec_q.size() >= base + 2}, 32'd1);
        if (dec_q.size() >= base + 2) begin
            check("lit_left", {15'd0, dec_q[base]}, {15'd0, 1'b0, 16'hA5C3});
            check("lit_right", {15'd0, dec_q[base+1]}, {15'd0, 1'b1, 16'h8001});
        end

        // streaming 100+ frames with in_valid held high
        reset_dut();
        base = dec_q.size(); b_und = und_seen; b_edges = lo_edges;
        acc_q.delete();
        p = 16'h0100;
        in_valid = 1'b1; l_data = 16'(p); r_data = ~16'(p);
        for (int i = 0; i < 3 + 12869; i++) begin
            if (i == 3) en = 1'b1;
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc_q.push_back({l_data, r_data});
                p++;
                l_data = 16'(p); r_data = ~16'(p);
            end
        end
        in_valid = 1'b0;
        check("stream_frames", lo_edges - b_edges, 32'd101);
        check("stream_one_accept_per_frame", acc_q.size(), lo_edges - b_edges + 1);
        check("stream_no_underrun", und_seen - b_und, 32'd0);
        nd = dec_q.size() - base;
        check("stream_dec_count", {31'd0, nd >= 200}, 32'd1);
        for (int i = 0; i < nd; i++) begin
            if (i / 2 < acc_q.size()) begin
                pr = acc_q[i/2];
                expw = (i % 2 == 0) ? {1'b0, pr[2*D-1 -: D]} : {1'b1, pr[D-1:0]};
                check("stream_word", {15'd0, dec_q[base+i]}, {15'd0, expw});
            end
        end

        // en dropped at bitcnt 5: frame completes then idles
        reset_dut();
        start_run();
        wait_n(26);
        en = 1'b0;
        wait_n(106);
        check("stop_bclk", {31'd0, bclk}, 32'd0);
        check("stop_lrck", {31'd0, lrck}, 32'd1);
        check("stop_sdata", {31'd0, sdata}, 32'd0);
        b_all = r_all;
        wait_n(40);
        check("stop_no_bclk", r_all - b_all, 32'd0);

        // en dropped at bitcnt 5, restored at bitcnt 20: no gap
        reset_dut();
        start_run();
        wait_n(26);
        en = 1'b0;
        wait_n(60);
        en = 1'b1;
        wait_n(46);
        b_all = r_all;
        wait_n(40);
        check("resume_bclk_rises", r_all - b_all, 32'd10);

        // reset at bitcnt 9 with the buffer full
        reset_dut();
        offer(16'h00FF, 16'h1234);
        start_run();
        wait_n(5);
        offer(16'h5555, 16'hAAAA);
        wait_n(36);
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("pre_rst_bclk", {31'd0, bclk}, 32'd1);
        check("pre_rst_sdata", {31'd0, sdata}, 32'd1);
        check("pre_rst_lrck", {31'd0, lrck}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bclk", {31'd0, bclk}, 32'd0);
        check("mid_rst_lrck", {31'd0, lrck}, 32'd1);
        check("mid_rst_sdata", {31'd0, sdata}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        wait_n(1);

        // starve 3 frames
        reset_dut();
        b_und = und_seen;
        start_run();
        wait_n(300);
        check("starve_pulses", und_seen - b_und, 32'd3);
        check("starve_cnt", {16'd0, underrun_cnt}, (CNT_ON != 0) ? 32'd3 : 32'd0);

        // randomized traffic and en toggling against the model
        reset_dut();
        en = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            wait_n(1);
            if ($urandom_range(0, 299) == 0) en = ~en;
            in_valid = ($urandom_range(0, 99) < 2);
            l_data = 16'($urandom);
            r_data = 16'($urandom);
        end
        in_valid = 1'b0;
        wait_n(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
